// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard sequencer.
package hazard_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // A source only creates a dependency when it is actually read and is not x0.
    function automatic logic src_match(input logic used, input logic [4:0] rs, input logic [4:0] rd);
        return used && (rs != REG_ZERO) && (rs == rd);
    endfunction

endpackage

// File: rtl/muldiv_stall_fsm.sv
// Purpose: tracks a multi-cycle MUL/DIV occupying EX and raises md_hz until its release cycle.
// Latency: md_hz/muldiv_done are combinational from state and start; occupancy is MULDIV_CYCLES cycles.
// Backpressure: start is ignored while BUSY; the pipeline is held via md_hz.
module muldiv_stall_fsm
    import hazard_pkg::*;
#(
    parameter int MULDIV_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic EX_muldiv_start,
    output logic md_hz,
    output logic muldiv_done
);

    localparam logic [7:0] CNT_LOAD = 8'(MULDIV_CYCLES - 2);

    md_state_t  state;
    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (EX_muldiv_start) begin
                        state <= BUSY;
                        cnt   <= CNT_LOAD;
                    end
                end
                BUSY: begin
                    if (cnt == 8'd0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 8'd0;
                end
            endcase
        end
    end

    // The start cycle itself already stalls; the final BUSY cycle is the release.
    assign md_hz       = ((state == IDLE) && EX_muldiv_start) || ((state == BUSY) && (cnt != 8'd0));
    assign muldiv_done = (state == BUSY) && (cnt == 8'd0);

endmodule

// File: rtl/hazard_control_unit.sv
// Purpose: IF/ID stall, ID/EX bubble and IF/ID flush control for the 5-stage core; MUL/DIV tracking under HAZARD_MULDIV_EN.
// Latency: all hazard outputs are combinational from current inputs and FSM state; stall_count updates next edge.
// Backpressure: upstream is held via stall_IF/stall_ID, EX via stall_EX; no flow-control handshake.
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int MULDIV_CYCLES = 8,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_Rs1,
    input  logic [4:0]       ID_Rs2,
    input  logic             ID_uses_rs1,
    input  logic             ID_uses_rs2,
    input  logic             ID_is_branch,
    input  logic             ID_is_store,
    input  logic             ID_branch_taken,
    input  logic             EX_RegWrite,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_Rd,
    input  logic             MEM_MemRead,
    input  logic [4:0]       MEM_Rd,
    input  logic             EX_muldiv_start,
    output logic             stall_IF,
    output logic             stall_ID,
    output logic             bubble_EX,
    output logic             stall_EX,
    output logic             bubble_MEM,
    output logic             flush_ID,
    output logic             muldiv_done,
    output logic [CNT_W-1:0] stall_count
);

    logic ex_m1, ex_m2, mem_m1, mem_m2;
    logic ld_hz, br_hz, md_hz, any_stall;

    assign ex_m1  = src_match(ID_uses_rs1, ID_Rs1, EX_Rd);
    assign ex_m2  = src_match(ID_uses_rs2, ID_Rs2, EX_Rd);
    assign mem_m1 = src_match(ID_uses_rs1, ID_Rs1, MEM_Rd);
    assign mem_m2 = src_match(ID_uses_rs2, ID_Rs2, MEM_Rd);

    // Store data (rs2) reaches memory through the MEM forwarding path, so it never load-use stalls.
    assign ld_hz = EX_MemRead && (ex_m1 || (ex_m2 && !ID_is_store));
    assign br_hz = ID_is_branch &&
                   ((EX_RegWrite && (ex_m1 || ex_m2)) || (MEM_MemRead && (mem_m1 || mem_m2)));

`ifdef HAZARD_MULDIV_EN
    muldiv_stall_fsm #(
        .MULDIV_CYCLES (MULDIV_CYCLES)
    ) u_muldiv_stall_fsm (
        .clk             (clk),
        .rst             (rst),
        .EX_muldiv_start (EX_muldiv_start),
        .md_hz           (md_hz),
        .muldiv_done     (muldiv_done)
    );
`else
    logic unused_muldiv_start;
    assign unused_muldiv_start = EX_muldiv_start;
    assign md_hz       = 1'b0;
    assign muldiv_done = 1'b0;
`endif

    assign any_stall  = ld_hz || br_hz || md_hz;
    assign stall_IF   = any_stall;
    assign stall_ID   = any_stall;
    // While EX is held the ID/EX register must keep its MUL/DIV, so no bubble is loaded.
    assign bubble_EX  = (ld_hz || br_hz) && !md_hz;
    assign stall_EX   = md_hz;
    assign bubble_MEM = md_hz;
    assign flush_ID   = ID_branch_taken && !any_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if (any_stall && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit with a cycle-level reference model; follows HAZARD_MULDIV_EN.
module tb_hazard_control_unit;

    localparam int MDC   = 8;
    localparam int CW    = 4;
`ifdef HAZARD_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    ID_Rs1, ID_Rs2, EX_Rd, MEM_Rd;
    logic          ID_uses_rs1, ID_uses_rs2, ID_is_branch, ID_is_store, ID_branch_taken;
    logic          EX_RegWrite, EX_MemRead, MEM_MemRead, EX_muldiv_start;
    logic          stall_IF, stall_ID, bubble_EX, stall_EX, bubble_MEM, flush_ID, muldiv_done;
    logic [CW-1:0] stall_count;

    int checks   = 0;
    int failures = 0;

    hazard_control_unit #(.MULDIV_CYCLES(MDC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .ID_Rs1(ID_Rs1), .ID_Rs2(ID_Rs2),
        .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2),
        .ID_is_branch(ID_is_branch), .ID_is_store(ID_is_store),
        .ID_branch_taken(ID_branch_taken),
        .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_Rd(EX_Rd),
        .MEM_MemRead(MEM_MemRead), .MEM_Rd(MEM_Rd),
        .EX_muldiv_start(EX_muldiv_start),
        .stall_IF(stall_IF), .stall_ID(stall_ID), .bubble_EX(bubble_EX),
        .stall_EX(stall_EX), .bubble_MEM(bubble_MEM), .flush_ID(flush_ID),
        .muldiv_done(muldiv_done), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // Reference model: md_age = number of cycles the current MUL/DIV has already spent in EX.
    int  md_age     = 0;
    int  m_count    = 0;
    bit  model_live = 1'b0;
    bit  e_ld, e_br, e_md, e_stall, e_done;

    function automatic bit dep(input logic used, input logic [4:0] rs, input logic [4:0] rd);
        return used && rs != 5'd0 && rs == rd;
    endfunction

    always @* begin
        e_ld    = EX_MemRead && (dep(ID_uses_rs1, ID_Rs1, EX_Rd) ||
                                 (dep(ID_uses_rs2, ID_Rs2, EX_Rd) && !ID_is_store));
        e_br    = ID_is_branch &&
                  ((EX_RegWrite && (dep(ID_uses_rs1, ID_Rs1, EX_Rd) || dep(ID_uses_rs2, ID_Rs2, EX_Rd))) ||
                   (MEM_MemRead && (dep(ID_uses_rs1, ID_Rs1, MEM_Rd) || dep(ID_uses_rs2, ID_Rs2, MEM_Rd))));
        e_md    = MD_EN && ((md_age == 0 && EX_muldiv_start) || (md_age >= 1 && md_age <= MDC - 2));
        e_done  = MD_EN && (md_age == MDC - 1);
        e_stall = e_ld || e_br || e_md;
    end

    always @(posedge clk) begin
        if (rst) begin
            md_age  = 0;
            m_count = 0;
        end else begin
            if (e_stall && m_count < (1 << CW) - 1) m_count = m_count + 1;
            if (!MD_EN)                            md_age = 0;
            else if (md_age == 0)                  md_age = EX_muldiv_start ? 1 : 0;
            else                                   md_age = (md_age == MDC - 1) ? 0 : md_age + 1;
        end
        model_live = 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (model_live) begin
            chk("m_stall_IF",    32'(stall_IF),    32'(e_stall));
            chk("m_stall_ID",    32'(stall_ID),    32'(e_stall));
            chk("m_bubble_EX",   32'(bubble_EX),   32'((e_ld || e_br) && !e_md));
            chk("m_stall_EX",    32'(stall_EX),    32'(e_md));
            chk("m_bubble_MEM",  32'(bubble_MEM),  32'(e_md));
            chk("m_flush_ID",    32'(flush_ID),    32'(ID_branch_taken && !e_stall));
            chk("m_muldiv_done", 32'(muldiv_done), 32'(e_done));
            chk("m_stall_count", 32'(stall_count), 32'(m_count));
        end
    end

    int done_pulses = 0;
    always @(negedge clk) if (muldiv_done === 1'b1) done_pulses = done_pulses + 1;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear();
        ID_Rs1 = 0; ID_Rs2 = 0; ID_uses_rs1 = 0; ID_uses_rs2 = 0;
        ID_is_branch = 0; ID_is_store = 0; ID_branch_taken = 0;
        EX_RegWrite = 0; EX_MemRead = 0; EX_Rd = 0;
        MEM_MemRead = 0; MEM_Rd = 0; EX_muldiv_start = 0;
    endtask

    initial begin
        rst = 1'b1;
        clear();
        step(); step();
        @(negedge clk);
        chk("rst_stall_IF",    32'(stall_IF),    0);
        chk("rst_stall_count", 32'(stall_count), 0);
        chk("rst_muldiv_done", 32'(muldiv_done), 0);
        chk("rst_stall_EX",    32'(stall_EX),    0);
        rst = 1'b0;

        // load-use: lw x5 in EX, add reading x5 in ID
        step(); EX_MemRead = 1; EX_RegWrite = 1; EX_Rd = 5; ID_Rs1 = 5; ID_uses_rs1 = 1;
        @(negedge clk);
        chk("lu_stall",  32'(stall_IF),  1);
        chk("lu_bubble", 32'(bubble_EX), 1);
        step(); EX_MemRead = 0; EX_RegWrite = 0; EX_Rd = 0; MEM_MemRead = 1; MEM_Rd = 5;
        @(negedge clk);
        chk("lu_release", 32'(stall_IF),    0);
        chk("lu_count",   32'(stall_count), 1);

        // store after load: data source exempt, address source not
        step(); clear(); EX_MemRead = 1; EX_RegWrite = 1; EX_Rd = 5;
        ID_is_store = 1; ID_Rs1 = 2; ID_Rs2 = 5; ID_uses_rs1 = 1; ID_uses_rs2 = 1;
        @(negedge clk);
        chk("st_data_nostall", 32'(stall_IF), 0);
        step(); ID_Rs1 = 5;
        @(negedge clk);
        chk("st_addr_stall", 32'(stall_IF), 1);

        // beq x7,x0 after lw x7: two stall cycles, then redirect
        step(); clear(); EX_MemRead = 1; EX_RegWrite = 1; EX_Rd = 7;
        ID_is_branch = 1; ID_Rs1 = 7; ID_Rs2 = 0; ID_uses_rs1 = 1; ID_uses_rs2 = 1; ID_branch_taken = 1;
        @(negedge clk);
        chk("brld_c1_stall", 32'(stall_IF), 1);
        chk("brld_c1_flush", 32'(flush_ID), 0);
        step(); EX_MemRead = 0; EX_RegWrite = 0; EX_Rd = 0; MEM_MemRead = 1; MEM_Rd = 7;
        @(negedge clk);
        chk("brld_c2_stall",  32'(stall_IF),  1);
        chk("brld_c2_bubble", 32'(bubble_EX), 1);
        chk("brld_c2_flush",  32'(flush_ID),  0);
        step(); MEM_MemRead = 0; MEM_Rd = 0;
        @(negedge clk);
        chk("brld_c3_stall", 32'(stall_IF), 0);
        chk("brld_c3_flush", 32'(flush_ID), 1);

        // branch on an ALU result in EX: one stall cycle
        step(); clear(); EX_RegWrite = 1; EX_Rd = 3;
        ID_is_branch = 1; ID_Rs2 = 3; ID_uses_rs2 = 1; ID_branch_taken = 1;
        @(negedge clk);
        chk("bralu_c1_stall", 32'(stall_IF), 1);
        step(); EX_RegWrite = 0; EX_Rd = 0; MEM_Rd = 3;
        @(negedge clk);
        chk("bralu_c2_stall", 32'(stall_IF), 0);
        chk("bralu_c2_flush", 32'(flush_ID), 1);

        // x0 never creates a dependency; unread sources neither
        step(); clear(); EX_MemRead = 1; EX_RegWrite = 1; EX_Rd = 0; ID_Rs1 = 0; ID_uses_rs1 = 1;
        @(negedge clk);
        chk("x0_nostall", 32'(stall_IF), 0);
        step(); EX_Rd = 5; ID_Rs1 = 5; ID_uses_rs1 = 0;
        @(negedge clk);
        chk("unused_nostall", 32'(stall_IF), 0);

        // MUL/DIV held in EX, then an immediate second one with a branch hazard in ID
        step(); clear(); EX_muldiv_start = 1;
        for (int i = 0; i < MDC; i++) begin
            if (i > 0) step();
            @(negedge clk);
            chk("md1_stall_EX", 32'(stall_EX),    MD_EN ? 32'(i < MDC - 1) : 0);
            chk("md1_done",     32'(muldiv_done), MD_EN ? 32'(i == MDC - 1) : 0);
        end
        step(); EX_RegWrite = 1; EX_Rd = 9; ID_is_branch = 1; ID_Rs1 = 9; ID_uses_rs1 = 1;
        for (int i = 0; i < MDC; i++) begin
            if (i > 0) step();
            @(negedge clk);
            chk("md2_stall_IF",  32'(stall_IF),    1);
            chk("md2_bubble_EX", 32'(bubble_EX),   MD_EN ? 32'(i == MDC - 1) : 1);
            chk("md2_done",      32'(muldiv_done), MD_EN ? 32'(i == MDC - 1) : 0);
        end

        // reset on the third BUSY cycle aborts without a done pulse
        step(); clear(); EX_muldiv_start = 1; done_pulses = 0;
        step(); step();
        step(); rst = 1; EX_muldiv_start = 0;
        step(); rst = 0;
        @(negedge clk);
        chk("rstmd_stall_EX", 32'(stall_EX),    0);
        chk("rstmd_count",    32'(stall_count), 0);
        step(); step();
        @(negedge clk);
        chk("rstmd_no_done", 32'(done_pulses), 0);

        // counter saturates at all-ones
        step(); EX_MemRead = 1; EX_Rd = 5; ID_Rs1 = 5; ID_uses_rs1 = 1;
        repeat (19) step();
        step(); clear();
        @(negedge clk);
        chk("sat_count", 32'(stall_count), 32'((1 << CW) - 1));

        step(); step();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Pipeline hazard sequencer for the 5-stage core. It decides when the IF/ID stages must stall, when a bubble is injected into ID/EX, and when ID is flushed on a taken branch. It covers every hazard that the ALU, memory and branch-ALU forwarding paths cannot resolve: load-use, branch-in-ID operand dependencies, and an optional multi-cycle MUL/DIV occupying EX. It sits beside the forwarding units and drives the pipeline-register enables and clears.

## Interface
- `MULDIV_CYCLES`, default 8: total cycles a MUL/DIV occupies EX; legal range 2..255.
- `CNT_W`, default 32: width of the stall performance counter.

Ports:
- `clk`  in  1  core clock
- `rst`  in  1  synchronous, active-high reset
- `ID_Rs1`, `ID_Rs2`  in  5 each  source registers of the instruction in ID
- `ID_uses_rs1`, `ID_uses_rs2`  in  1 each  ID instruction actually reads that source
- `ID_is_branch`  in  1  ID instruction is a branch or JALR; its operands are resolved in ID
- `ID_is_store`  in  1  ID instruction is a store; rs2 is the store data
- `ID_branch_taken`  in  1  branch ALU redirect from ID
- `EX_RegWrite`, `EX_MemRead`  in  1 each  control of the instruction in EX
- `EX_Rd`  in  5  destination register of the instruction in EX
- `MEM_MemRead`  in  1  the instruction in MEM is a load
- `MEM_Rd`  in  5  destination register of the instruction in MEM
- `EX_muldiv_start`  in  1  the instruction in EX is MUL/DIV; held high while it stays in EX
- `stall_IF`  out  1  hold PC and IF/ID
- `stall_ID`  out  1  hold the ID contents
- `bubble_EX`  out  1  load a NOP into ID/EX
- `stall_EX`  out  1  hold ID/EX
- `bubble_MEM`  out  1  load a NOP into EX/MEM
- `flush_ID`  out  1  clear IF/ID (taken branch)
- `muldiv_done`  out  1  the MUL/DIV result is valid in EX this cycle
- `stall_count`  out  CNT_W  number of cycles with `stall_IF` high

## Operation
A source register "matches" only when it is used and nonzero.
- Load-use: `EX_MemRead`, and `EX_Rd` matches rs1, or matches rs2 with `!ID_is_store` → `ld_hz`. A store's rs2 is covered by memory forwarding.
- Branch hazards (`ID_is_branch` only):
  - `EX_RegWrite` with `EX_Rd` matching rs1 or rs2 → `br_hz`. A load in EX produces a second stall naturally, through the MEM rule.
  - `MEM_MemRead` with `MEM_Rd` matching → `br_hz`.
- MUL/DIV FSM states:
  - IDLE → BUSY on `EX_muldiv_start`; `cnt` loads MULDIV_CYCLES-2.
  - BUSY decrements `cnt`. When `cnt`==0, BUSY → IDLE, and `muldiv_done` is high for that cycle.
  - `EX_muldiv_start` is ignored while in BUSY.
- `md_hz` = (IDLE & `EX_muldiv_start`) | (BUSY & `cnt`!=0).
- Outputs:
  - `stall_IF` = `stall_ID` = `ld_hz` | `br_hz` | `md_hz`
  - `bubble_EX` = (`ld_hz` | `br_hz`) & !`md_hz`
  - `stall_EX` = `bubble_MEM` = `md_hz`
  - `flush_ID` = `ID_branch_taken` & !`stall_ID`. A branch evaluated on stale operands never redirects.
- `stall_count` increments on every cycle with `stall_IF` high and saturates at all-ones.

## Timing
- All hazard outputs are combinational from the current-cycle inputs and FSM state; there is no added latency.
- Reset values: FSM IDLE, `cnt`=0, `stall_count`=0, `muldiv_done`=0. All combinational outputs are 0 while reset is held with idle inputs.
- A MUL/DIV occupies EX for exactly MULDIV_CYCLES cycles: MULDIV_CYCLES-1 stalled cycles, then one release cycle with `muldiv_done`=1.
- Back-to-back MUL/DIV: a start arriving in the cycle after the release begins a new sequence.
- Reset asserted mid-BUSY returns to IDLE on the next edge; no done pulse is produced.
- A branch depending on a load in EX stalls for exactly 2 cycles. A branch depending on an ALU op in EX stalls for exactly 1 cycle.

## Configuration
- `HAZARD_MULDIV_EN` defined: the FSM, `cnt`, `stall_EX`, `bubble_MEM` and `muldiv_done` are implemented as described above.
- `HAZARD_MULDIV_EN` undefined: the FSM is not built. `md_hz`=0, and `stall_EX`, `bubble_MEM` and `muldiv_done` are tied to 0. `EX_muldiv_start` is ignored.

## Structure
- Shared package `hazard_pkg`: `md_state_t` enum (IDLE, BUSY) and the `REG_ZERO` constant (5'd0).
- One sub-module, `muldiv_stall_fsm`: holds the FSM and `cnt`, and outputs `md_hz`/`muldiv_done`. It is instantiated only under `HAZARD_MULDIV_EN`.

## Test plan
1. Load-use: EX is `lw x5` (`EX_MemRead`=1, `EX_Rd`=5) and ID is `add` reading x5 → `stall_IF`=1 and `bubble_EX`=1 for one cycle; `stall_count`=1.
2. Store after load: EX is `lw x5`, ID is `sw` with rs2=5 and rs1=2 → no stall. With rs1=5 instead → 1-cycle stall.
3. Branch after load: `lw x7` then `beq x7,x0` → stall for 2 cycles. `flush_ID` stays 0 while stalled, then follows `ID_branch_taken`.
4. x0 dependency: EX_Rd=0 with EX_MemRead=1, and ID reads x0 → no stall.
5. MUL/DIV with MULDIV_CYCLES=8: `EX_muldiv_start` is held → `stall_EX` is high for 7 cycles, then `muldiv_done`=1 on cycle 8. A second start immediately after repeats the sequence. With the macro undefined, no stall occurs.
6. Assert `rst` on the 3rd BUSY cycle → next cycle is IDLE, `stall_count`=0, and `muldiv_done` never pulses.
